// File: rtl/inst_encoder.sv
// Streaming RISC-V instruction encoder: packs decoded fields into a 32-bit word,
// checks immediate range/alignment, and buffers {inst, addr, err} in a 2-entry FIFO.
module inst_encoder #(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              restart,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_fmt,
  input  logic [6:0]        in_opcode,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [2:0]        in_funct3,
  input  logic [6:0]        in_funct7,
  input  logic [31:0]       in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_inst,
  output logic [ADDR_W-1:0] out_addr,
  output logic [1:0]        out_err,
  output logic [7:0]        err_count,
  output logic              addr_wrap
);

  localparam logic [31:0]       NOP  = 32'h0000_0013;
  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

  // A signed value fits in N bits when all bits from N-1 upward are copies of the sign.
  function automatic logic sign_fits(input logic [31:0] v, input int n);
    logic [31:0] hi;
    hi = v >> (n - 1);
    return (hi == 32'h0000_0000) || (hi == (32'hFFFF_FFFF >> (n - 1)));
  endfunction

  logic [31:0]       raw_inst;
  logic [1:0]        enc_err;
  logic [31:0]       enc_inst;
  logic [ADDR_W-1:0] addr_cnt;
  logic              accept;
  logic              pop;
  logic              sk_valid;
  logic [31:0]       sk_inst;
  logic [ADDR_W-1:0] sk_addr;
  logic [1:0]        sk_err;

  assign in_ready = !(out_valid && sk_valid);
  assign accept   = in_valid && in_ready;
  assign pop      = out_valid && out_ready;

  // Field placement and fmt > range > alignment checks.
  always_comb begin
    raw_inst = 32'h0000_0000;
    enc_err  = 2'd0;
    case (in_fmt)
      3'd0: begin
        raw_inst = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
        enc_err  = 2'd0;
      end
      3'd1: begin
        raw_inst = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
        if (!sign_fits(in_imm, 12)) enc_err = 2'd1;
        else                        enc_err = 2'd0;
      end
      3'd2: begin
        raw_inst = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
        if (!sign_fits(in_imm, 12)) enc_err = 2'd1;
        else                        enc_err = 2'd0;
      end
      3'd3: begin
        raw_inst = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                    in_imm[4:1], in_imm[11], in_opcode};
        if (!sign_fits(in_imm, 13)) enc_err = 2'd1;
        else if (in_imm[0])         enc_err = 2'd2;
        else                        enc_err = 2'd0;
      end
      3'd4: begin
        raw_inst = {in_imm[31:12], in_rd, in_opcode};
        if (in_imm[11:0] != 12'h000) enc_err = 2'd2;
        else                         enc_err = 2'd0;
      end
      3'd5: begin
        raw_inst = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
        if (!sign_fits(in_imm, 21)) enc_err = 2'd1;
        else if (in_imm[0])         enc_err = 2'd2;
        else                        enc_err = 2'd0;
      end
      default: begin
        raw_inst = 32'h0000_0000;
        enc_err  = 2'd3;
      end
    endcase
    if (enc_err != 2'd0) enc_inst = NOP;
    else                 enc_inst = raw_inst;
  end

  // Address counter, sticky wrap flag and saturating error count; restart wins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_cnt  <= BASE;
      addr_wrap <= 1'b0;
      err_count <= 8'd0;
    end else if (restart) begin
      addr_cnt  <= BASE;
      addr_wrap <= 1'b0;
      err_count <= 8'd0;
    end else if (accept) begin
      addr_cnt <= addr_cnt + {{(ADDR_W-1){1'b0}}, 1'b1};
      if (addr_cnt == {ADDR_W{1'b1}}) addr_wrap <= 1'b1;
      if (enc_err != 2'd0 && err_count != 8'hFF) err_count <= err_count + 8'd1;
    end
  end

  // Two-entry FIFO: the head lives directly in the output registers, sk_* is the second slot.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_inst  <= 32'h0000_0000;
      out_addr  <= {ADDR_W{1'b0}};
      out_err   <= 2'd0;
      sk_valid  <= 1'b0;
      sk_inst   <= 32'h0000_0000;
      sk_addr   <= {ADDR_W{1'b0}};
      sk_err    <= 2'd0;
    end else if (pop && sk_valid) begin
      out_inst <= sk_inst;
      out_addr <= sk_addr;
      out_err  <= sk_err;
      sk_valid <= accept;
      if (accept) begin
        sk_inst <= enc_inst;
        sk_addr <= addr_cnt;
        sk_err  <= enc_err;
      end
    end else if (pop || (accept && !out_valid)) begin
      out_valid <= accept;
      if (accept) begin
        out_inst <= enc_inst;
        out_addr <= addr_cnt;
        out_err  <= enc_err;
      end
    end else if (accept) begin
      sk_valid <= 1'b1;
      sk_inst  <= enc_inst;
      sk_addr  <= addr_cnt;
      sk_err   <= enc_err;
    end
  end

endmodule

// File: tb/tb_inst_encoder.sv
// Table-driven bench for inst_encoder with a scoreboard queue and a small
// cycle model of address, wrap flag, error count and FIFO occupancy.
module tb_inst_encoder;
  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          reset_n, restart, in_valid, in_ready, out_valid, out_ready, addr_wrap;
  logic [2:0]    in_fmt, in_funct3;
  logic [6:0]    in_opcode, in_funct7;
  logic [4:0]    in_rd, in_rs1, in_rs2;
  logic [31:0]   in_imm, out_inst;
  logic [AW-1:0] out_addr;
  logic [1:0]    out_err;
  logic [7:0]    err_count;

  always #5 clk = ~clk;

  inst_encoder #(.ADDR_W(AW), .BASE_ADDR(0)) dut (
    .clk(clk), .reset_n(reset_n), .restart(restart),
    .in_valid(in_valid), .in_ready(in_ready), .in_fmt(in_fmt), .in_opcode(in_opcode),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_funct3(in_funct3),
    .in_funct7(in_funct7), .in_imm(in_imm), .out_valid(out_valid), .out_ready(out_ready),
    .out_inst(out_inst), .out_addr(out_addr), .out_err(out_err),
    .err_count(err_count), .addr_wrap(addr_wrap)
  );

  typedef struct {
    logic [2:0] fmt; logic [6:0] op; logic [4:0] rd, rs1, rs2;
    logic [2:0] f3;  logic [6:0] f7; logic [31:0] imm;
    logic [31:0] inst; logic [1:0] err;
  } vec_t;
  typedef struct { logic [31:0] inst; logic [AW-1:0] addr; logic [1:0] err; } exp_t;

  vec_t          vecs[20];
  exp_t          q[$];
  int            errors = 0;
  int            checks = 0;
  int            cur = 0;
  logic [AW-1:0] m_addr = '0;
  logic          m_wrap = 1'b0;
  int            m_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void setv(input int i, input logic [2:0] fmt, input logic [6:0] op,
                               input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] imm,
                               input logic [31:0] inst, input logic [1:0] err);
    vecs[i] = '{fmt, op, rd, rs1, rs2, f3, f7, imm, inst, err};
  endfunction

  task automatic drive(input int i);
    cur       = i;
    in_fmt    = vecs[i].fmt;  in_opcode = vecs[i].op;  in_rd = vecs[i].rd;
    in_rs1    = vecs[i].rs1;  in_rs2    = vecs[i].rs2; in_funct3 = vecs[i].f3;
    in_funct7 = vecs[i].f7;   in_imm    = vecs[i].imm;
    in_valid  = 1'b1;
  endtask

  task automatic wait_accept();
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk); #1;
        in_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    checks++;
    errors++;
    $display("FAIL accept_timeout: in_ready stayed low for 20 cycles at %0t", $time);
    in_valid = 1'b0;
  endtask

  task automatic send(input int i);
    drive(i);
    wait_accept();
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Scoreboard / model: compare state from the last edge, then predict the next edge.
  initial forever begin
    @(negedge clk);
    if (!reset_n) begin
      q.delete();
      m_addr = '0; m_wrap = 1'b0; m_cnt = 0;
    end else begin
      bit acc;
      acc = in_valid && (q.size() < 2);
      check("in_ready", 32'(in_ready), 32'(q.size() < 2));
      check("out_valid", 32'(out_valid), 32'(q.size() > 0));
      check("err_count", 32'(err_count), 32'(m_cnt));
      check("addr_wrap", 32'(addr_wrap), 32'(m_wrap));
      if (q.size() > 0) begin
        check("out_inst", out_inst, q[0].inst);
        check("out_addr", 32'(out_addr), 32'(q[0].addr));
        check("out_err", 32'(out_err), 32'(q[0].err));
        if (out_ready) void'(q.pop_front());
      end
      if (acc) begin
        q.push_back('{vecs[cur].inst, m_addr, vecs[cur].err});
        if (vecs[cur].err != 2'd0 && m_cnt < 255) m_cnt++;
        if (m_addr == {AW{1'b1}}) m_wrap = 1'b1;
        m_addr = m_addr + 1'b1;
      end
      if (restart) begin
        m_addr = '0; m_wrap = 1'b0; m_cnt = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    //       i  fmt  op     rd  rs1 rs2 f3  f7     imm            inst           err
    setv( 0, 3'd1, 7'h13, 1,  0,  0,  0, 7'h00, 32'h0000_0005, 32'h0050_0093, 2'd0);
    setv( 1, 3'd3, 7'h63, 0,  1,  2,  0, 7'h00, 32'hFFFF_FFF8, 32'hFE20_8CE3, 2'd0);
    setv( 2, 3'd4, 7'h37, 5,  0,  0,  0, 7'h00, 32'h1234_5000, 32'h1234_52B7, 2'd0);
    setv( 3, 3'd5, 7'h6F, 1,  0,  0,  0, 7'h00, 32'h0000_0800, 32'h0010_00EF, 2'd0);
    setv( 4, 3'd1, 7'h13, 1,  0,  0,  0, 7'h00, 32'h0000_0800, 32'h0000_0013, 2'd1);
    setv( 5, 3'd3, 7'h63, 0,  1,  2,  0, 7'h00, 32'h0000_0003, 32'h0000_0013, 2'd2);
    setv( 6, 3'd7, 7'h13, 0,  0,  0,  0, 7'h00, 32'h0000_0000, 32'h0000_0013, 2'd3);
    setv( 7, 3'd0, 7'h33, 3,  1,  2,  0, 7'h20, 32'hFFFF_FFFF, 32'h4020_81B3, 2'd0);
    setv( 8, 3'd2, 7'h23, 0,  1,  2,  2, 7'h00, 32'hFFFF_FFFC, 32'hFE20_AE23, 2'd0);
    setv( 9, 3'd1, 7'h13, 1,  0,  0,  0, 7'h00, 32'hFFFF_F800, 32'h8000_0093, 2'd0);
    setv(10, 3'd1, 7'h13, 1,  0,  0,  0, 7'h00, 32'h0000_07FF, 32'h7FF0_0093, 2'd0);
    setv(11, 3'd5, 7'h6F, 1,  0,  0,  0, 7'h00, 32'hFFEF_FFFE, 32'h0000_0013, 2'd1);
    setv(12, 3'd5, 7'h6F, 1,  0,  0,  0, 7'h00, 32'h0000_0001, 32'h0000_0013, 2'd2);
    setv(13, 3'd6, 7'h13, 1,  0,  0,  0, 7'h00, 32'h0000_0001, 32'h0000_0013, 2'd3);
    setv(14, 3'd3, 7'h63, 0,  0,  0,  0, 7'h00, 32'h0000_1001, 32'h0000_0013, 2'd1);
    setv(15, 3'd3, 7'h63, 0,  0,  0,  0, 7'h00, 32'h0000_0FFE, 32'h7E00_0FE3, 2'd0);
    setv(16, 3'd4, 7'h37, 5,  0,  0,  0, 7'h00, 32'h1234_5001, 32'h0000_0013, 2'd2);
    setv(17, 3'd5, 7'h6F, 0,  0,  0,  0, 7'h00, 32'hFFF0_0000, 32'h8000_006F, 2'd0);
    setv(18, 3'd4, 7'h37, 1, 31, 31,  7, 7'h7F, 32'hFFFF_F000, 32'hFFFF_F0B7, 2'd0);
    setv(19, 3'd2, 7'h23, 0,  1,  2,  2, 7'h00, 32'h0000_0800, 32'h0000_0013, 2'd1);

    reset_n = 1'b0; restart = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_fmt = '0; in_opcode = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
    in_funct3 = '0; in_funct7 = '0; in_imm = '0;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_inst", out_inst, 32'd0);
    check("rst_out_addr", 32'(out_addr), 32'd0);
    check("rst_out_err", 32'(out_err), 32'd0);
    check("rst_err_count", 32'(err_count), 32'd0);
    check("rst_addr_wrap", 32'(addr_wrap), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #2 reset_n = 1'b1;
    idle(1);

    // Whole table back to back at full throughput; the 2-bit address wraps several times.
    for (int i = 0; i < 20; i++) send(i);
    idle(3);

    // Standalone restart, then five accepts: addresses 0,1,2,3,0 and wrap set.
    restart = 1'b1; idle(1); restart = 1'b0; idle(1);
    for (int k = 0; k < 5; k++) send(k);
    idle(3);
    check("wrap_after_five", 32'(addr_wrap), 32'd1);

    // Restart coincident with an errored accept: old address used, count ends at 0.
    drive(6); restart = 1'b1; wait_accept(); restart = 1'b0;
    idle(2);
    check("restart_err_count", 32'(err_count), 32'd0);

    // Backpressure: two accepted, third stalls until the output drains.
    out_ready = 1'b0;
    send(1); send(2); drive(3);
    idle(4);
    check("bp_in_ready", 32'(in_ready), 32'd0);
    check("bp_head_held", out_inst, 32'hFE20_8CE3);
    out_ready = 1'b1;
    wait_accept();
    idle(4);

    // Error count saturation.
    for (int k = 0; k < 260; k++) send(6);
    idle(3);
    check("err_sat", 32'(err_count), 32'd255);

    // Reset with two words queued.
    out_ready = 1'b0;
    send(0); send(7);
    #2 reset_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_err_count", 32'(err_count), 32'd0);
    out_ready = 1'b1;
    @(posedge clk); #2 reset_n = 1'b1;
    idle(1);
    send(10);
    idle(4);
    check("drain_empty", 32'(q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/inst_encoder.md
# inst_encoder

Streaming RISC-V instruction encoder: it packs decoded fields (format, opcode, registers, funct, signed immediate) into a 32-bit instruction word, with immediate range and alignment checks. It is the inverse of the core's immediate extraction. It sits between the boot/program loader and instruction memory, assigning each word a sequential word address. Encoded words are buffered in a 2-entry output FIFO with valid/ready handshakes on both sides.

## Interface
Parameters:
- ADDR_W, 8, width of the word-address counter
- BASE_ADDR, 0, address given to the first word after reset or restart

Ports:
- clk  in  1  clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- restart  in  1  synchronous: counter to BASE_ADDR, err_count and addr_wrap cleared
- in_valid  in  1  field set present
- in_ready  out  1  encoder can accept
- in_fmt  in  3  0=R, 1=I, 2=S, 3=B, 4=U, 5=J, 6/7 illegal
- in_opcode  in  7  opcode, placed in inst[6:0]
- in_rd, in_rs1, in_rs2  in  5 each  register indices
- in_funct3  in  3; in_funct7  in  7
- in_imm  in  32  signed byte offset (I/S/B/J) or full upper value (U)
- out_valid  out  1; out_ready  in  1
- out_inst  out  32  encoded word
- out_addr  out  ADDR_W  word address of out_inst
- out_err  out  2  0 ok, 1 imm out of range, 2 misaligned, 3 illegal fmt
- err_count  out  8  saturating count of words with out_err≠0
- addr_wrap  out  1  sticky, set when the address counter wraps

## Operation
- Accept on in_valid && in_ready. Entry = {inst, addr, err}; addr = current counter, then counter += 1.
- Field placement:
  - R: funct7|rs2|rs1|funct3|rd|opcode.
  - I: imm[11:0]|rs1|funct3|rd|opcode.
  - S: imm[11:5]|rs2|rs1|funct3|imm[4:0]|opcode.
  - B: imm[12]|imm[10:5]|rs2|rs1|funct3|imm[4:1]|imm[11]|opcode.
  - U: imm[31:12]|rd|opcode.
  - J: imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|opcode.
  - R ignores in_imm; U ignores rs1/rs2/funct.
- Checks, priority fmt > range > alignment:
  - I/S range is −2048..2047.
  - B range is −4096..4095 and imm[0] must be 0.
  - J range is −2^20..2^20−1 and imm[0] must be 0.
  - U requires imm[11:0]=0 (else code 2).
- An error word is still emitted with inst=32'h0000_0013 (NOP) and the address consumed. err_count increments, saturating at 255.
- Counter wraps from 2^ADDR_W−1 to 0 and sets addr_wrap.
- restart coincident with an accept: the accepted word takes the pre-restart address; the next accept gets BASE_ADDR; err_count ends at 0 even if the accepted word errored. restart does not flush the FIFO.
- FIFO: 2 entries, in order. in_ready = count<2, combinational from registered count only (no dependence on out_ready). Push and pop in the same cycle keep count unchanged.

## Timing
- Reset values (async, immediate):
  - out_valid 0, out_inst 0, out_addr 0, out_err 0.
  - err_count 0, addr_wrap 0, counter BASE_ADDR, FIFO empty.
  - in_ready 1.
- Latency: accept at edge N gives out_valid=1 after edge N when the FIFO was empty.
- The output is held stable while out_valid && !out_ready.
- Full throughput: 1 word/cycle with out_ready held high.
- Reset mid-operation discards FIFO contents; no partial word is emitted.

## Test plan
- I fmt, opcode 0x13, rd=1, rs1=0, funct3=0, imm=5 -> out_inst 0x00500093, out_addr 0, out_err 0, one cycle after accept.
- B fmt, opcode 0x63, rs1=1, rs2=2, imm=−8, then U lui rd=5 imm=0x12345000, then J jal rd=1 imm=2048 -> 0xFE208CE3, 0x123452B7, 0x001000EF at addresses 0, 1, 2.
- Error cases:
  - I imm=2048 -> err 1, inst 0x00000013.
  - B imm=3 -> err 2.
  - fmt=7 -> err 3.
  - err_count reaches 3; addresses still increment.
- Backpressure: out_ready low, three valid inputs -> two accepted, in_ready low on the third. Output held. Releasing out_ready drains in order, then the third is accepted.
- ADDR_W=2: five accepts -> addresses 0, 1, 2, 3, 0 and addr_wrap=1. restart -> next address BASE_ADDR, addr_wrap 0, err_count 0.
- Assert reset_n with 2 words queued -> out_valid 0 immediately. After release, first word at BASE_ADDR.
